fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Instruction-fetch stage of the rvga pipeline; sits directly upstream of decode.
//  Owns the PC, issues reads to instruction memory and buffers returned words.
//  Drives if_de_cword (pc + inst) into decode; bubbles are a canonical NOP.
//  Honours the shared pipeline stall and PC redirects from branch/jump resolution.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of first fetch after reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2)
//  NOP_INST   32'h0000_0013  instruction word used for bubbles (addi x0,x0,0)
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst_n        in   1           synchronous reset, active low
//  stall        in   1           hold if_de_cword; no buffer dequeue
//  redirect     in   1           flush and refetch from redirect_pc
//  redirect_pc  in   32          new PC; bits [1:0] forced to 0
//  imem_read    out  1           read request, held until imem_resp
//  imem_addr    out  32          request address, stable while imem_read=1
//  imem_resp    in   1           response valid for the outstanding read
//  imem_rdata   in   32          instruction word, valid with imem_resp
//  if_de_cword  out  rvga_cword  .pc/.inst driven; all other fields 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pc_q=RESET_PC, buffer empty, state S_REQ,
//   if_de_cword=0 with .inst=NOP_INST, .pc=0; imem_read=0 during reset cycle.
//  At most one outstanding read. imem_addr=pc_q; imem_read is a function of state,
//   registered space count and redirect (redirect=1 forces imem_read=0).
//  FSM:
//   S_REQ: imem_read=1 while (count + 0 outstanding) < BUF_DEPTH. On imem_resp:
//    push {pc_q, imem_rdata}, pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC->0), stay S_REQ.
//    If buffer would be full after push -> S_FULL.
//   S_FULL: imem_read=0; -> S_REQ once a dequeue frees an entry.
//   S_DROP: request outstanding for a dead path; imem_read=0 after the one in flight;
//    next imem_resp is discarded -> S_REQ.
//  Handshake: a request is in flight from first cycle imem_read=1 until imem_resp;
//   addr must not change while in flight, even on redirect.
//  Output: when stall=0, if_de_cword<=buffer head (dequeued) or NOP bubble if empty
//   (.pc of bubble = 0). Same-cycle resp into empty buffer is NOT bypassed: min
//   latency imem_resp -> if_de_cword = 2 cycles. stall=1: output and buffer held
//   (responses still pushed while space remains).
//  Redirect (priority over stall and imem_resp): buffer cleared, pc_q<=redirect_pc
//   &~3, if_de_cword<=NOP bubble. If a read is in flight and imem_resp=0 that
//   cycle -> S_DROP; if imem_resp=1 same cycle, data discarded -> S_REQ.
//  Simultaneous push+pop: count unchanged; push into full buffer never occurs.
//  Reset mid-fetch: in-flight response after reset is ignored only if it arrives
//   in the reset cycle; memory model must be reset alongside.
//  Count width: $clog2(BUF_DEPTH)+1; pointers wrap modulo BUF_DEPTH.
// TESTING
//  Reset, 1-cycle memory, stall=0 -> addrs 0,4,8..; cword.pc 0,4,8 with matching inst,
//   first valid inst 2 cycles after first imem_resp, bubbles before.
//  stall=1 for 5 cycles after 3 fetches -> output frozen, imem_read drops after 2
//   buffered words; release -> pc 0xC,0x10 emitted back-to-back, no loss/dup.
//  3-cycle memory latency, redirect to 0x100 in wait cycle 2 -> stale resp dropped,
//   next request addr 0x100, next non-NOP cword.pc=0x100.
//  redirect same cycle as imem_resp, redirect_pc=0x203 -> data discarded, addr 0x200.
//  RESET_PC=32'hFFFF_FFF8, 3 fetches -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  rst_n=0 for 1 cycle mid-stream with full buffer -> NOP output, fetch restarts at
//   RESET_PC, no stale buffered inst emitted.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight and buffers words for decode.
// Latency: imem_resp -> if_de_cword is 2 cycles minimum; stall holds output, redirect flushes everything.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
    } rvga_cword;
endpackage

module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output rvga_cword   if_de_cword
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      buf_pc_q   [BUF_DEPTH];
    logic [31:0]      buf_pc_d   [BUF_DEPTH];
    logic [31:0]      buf_inst_q [BUF_DEPTH];
    logic [31:0]      buf_inst_d [BUF_DEPTH];
    rvga_cword        cword_q, cword_d;
    rvga_cword        nop_cword;
    logic             push;
    logic             pop;

    always_comb begin
        nop_cword      = '0;
        nop_cword.inst = NOP_INST;

        imem_read = rst_n && !redirect && (state_q == S_REQ) && (cnt_q < DEPTH_C);
        // The in-flight address is frozen so a redirect cannot disturb the memory handshake.
        imem_addr = inflight_q ? addr_q : pc_q;

        push = !redirect && (state_q == S_REQ) && imem_resp;
        pop  = !redirect && !stall && (cnt_q != '0);

        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = imem_addr;
        inflight_d = imem_resp ? 1'b0 : (inflight_q || imem_read);
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        cword_d    = cword_q;

        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cword_d  = nop_cword;
            state_d  = (inflight_q && !imem_resp) ? S_DROP : S_REQ;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]   = pc_q;
                buf_inst_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d             = wr_ptr_q + 1'b1;
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                cword_d      = '0;
                cword_d.pc   = buf_pc_q[rd_ptr_q];
                cword_d.inst = buf_inst_q[rd_ptr_q];
                rd_ptr_d     = rd_ptr_q + 1'b1;
            end else if (!stall) begin
                cword_d = nop_cword;
            end
            cnt_d = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

            case (state_q)
                S_REQ:   if (push && cnt_d == DEPTH_C) state_d = S_FULL;
                S_FULL:  if (pop) state_d = S_REQ;
                S_DROP:  if (imem_resp) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cword_q    <= nop_cword;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cword_q    <= cword_d;
        end
    end

    // Buffer storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        buf_pc_q   <= buf_pc_d;
        buf_inst_q <= buf_inst_d;
    end

    assign if_de_cword = cword_q;

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: memory model + scoreboard queue of expected {pc, inst}, separate output monitor.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int          T_DEPTH    = 2;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    rvga_cword   if_de_cword;

    fetch #(.RESET_PC(T_RESET_PC), .BUF_DEPTH(T_DEPTH), .NOP_INST(T_NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_addr(imem_addr),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_de_cword(if_de_cword)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and memory-model state
    exp_t        q[$];
    logic [31:0] emit_pcs[$];
    int          emitted = 0;
    logic [29:0] salt = 30'h0;
    bit          busy = 0, dead = 0, resp_now = 0, pause = 0;
    int          rem = 0, lat = 1;
    logic [31:0] req_addr = 32'h0, exp_pc = T_RESET_PC;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ salt, 2'b10};
    endfunction

    function automatic rvga_cword mk_cw(input logic [31:0] pc, input logic [31:0] inst);
        rvga_cword c;
        c = '0;
        c.pc = pc;
        c.inst = inst;
        return c;
    endfunction

    // One clock of stimulus plus the memory model's response and request bookkeeping.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rs);
        @(posedge clk);
        #1;
        stall = st; redirect = rd; redirect_pc = rpc; rst_n = rs;
        imem_resp = 1'b0; imem_rdata = $urandom; resp_now = 0;
        if (!rs) begin
            busy = 0; dead = 0; exp_pc = T_RESET_PC;
        end else begin
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    resp_now = 1; imem_resp = 1'b1; imem_rdata = mem_word(req_addr);
                    if (!dead && !rd) begin
                        q.push_back('{req_addr, mem_word(req_addr), cyc});
                        exp_pc = req_addr + 32'd4;
                    end
                end
            end
            if (rd) begin
                exp_pc = rpc & ~32'h3;
                if (busy && !resp_now) dead = 1;
            end
        end
        @(negedge clk);
        if (busy) begin
            chk("read_held", 128'(imem_read), 128'(!dead && !rd));
            chk("addr_stable", 128'(imem_addr), 128'(req_addr));
            if (resp_now) busy = 0;
        end else if (!rs) begin
            chk("read_in_reset", 128'(imem_read), 128'(1'b0));
        end else if (imem_read && !pause) begin
            chk("req_addr", 128'(imem_addr), 128'(exp_pc));
            busy = 1; dead = 0; req_addr = imem_addr; rem = lat;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 1);
    endtask

    task automatic wait_mem(input int k, input string nm);
        int n;
        n = 0;
        while (!(busy && !dead && rem == k) && n < 60) begin
            step(0, 0, 32'h0, 1);
            n++;
        end
        chk(nm, 128'(busy && !dead && rem == k), 128'(1'b1));
    endtask

    task automatic wait_emits(input int target, input string nm);
        int n;
        n = 0;
        while (emitted < target && n < 80) begin
            step(0, 0, 32'h0, 1);
            n++;
        end
        #1;
        chk(nm, 128'(emitted >= target), 128'(1'b1));
    endtask

    // Output monitor: pops the scoreboard whenever decode should see a new word.
    rvga_cword mon_exp, last_cw;
    bit        p_rst_n = 0, p_redirect = 0, p_stall = 0;
    int        mon_cnt;
    always @(negedge clk) begin
        if (!p_rst_n || p_redirect) begin
            chk("flush_bubble", 128'(if_de_cword), 128'(mk_cw(32'h0, T_NOP)));
        end else if (p_stall) begin
            chk("stall_hold", 128'(if_de_cword), 128'(last_cw));
        end else if (q.size() > 0 && q[0].cyc <= cyc - 2) begin
            mon_exp = mk_cw(q[0].pc, q[0].inst);
            chk("emit", 128'(if_de_cword), 128'(mon_exp));
            emit_pcs.push_back(if_de_cword.pc);
            void'(q.pop_front());
            emitted++;
        end else begin
            chk("bubble", 128'(if_de_cword), 128'(mk_cw(32'h0, T_NOP)));
        end
        last_cw = if_de_cword;
        mon_cnt = 0;
        foreach (q[i]) if (q[i].cyc <= cyc - 1) mon_cnt++;
        if (rst_n && !redirect && mon_cnt >= T_DEPTH)
            chk("no_read_when_full", 128'(imem_read), 128'(1'b0));
        if (!rst_n || redirect) q.delete();
        p_rst_n = rst_n; p_redirect = redirect; p_stall = stall;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int mark;
        salt = 30'($urandom);

        // Reset then free-running 1-cycle memory
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        run(40);
        #1;
        chk("throughput", 128'(emitted >= 15), 128'(1'b1));
        chk("first_pc0", 128'(emit_pcs[0]), 128'(32'h0));
        chk("first_pc1", 128'(emit_pcs[1]), 128'(32'h4));
        chk("first_pc2", 128'(emit_pcs[2]), 128'(32'h8));

        // Stall long enough to fill the buffer, then release
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1);
        run(12);

        // 3-cycle memory, redirect during the second wait cycle
        lat = 3;
        wait_mem(2, "wait_req_for_drop");
        step(0, 1, 32'h0000_0100, 1);
        #1;
        mark = emitted;
        wait_emits(mark + 1, "emit_after_drop");
        chk("redirect_target", 128'(emit_pcs[mark]), 128'(32'h0000_0100));

        // Redirect in the same cycle as the response
        wait_mem(1, "wait_req_for_discard");
        step(0, 1, 32'h0000_0203, 1);
        #1;
        mark = emitted;
        wait_emits(mark + 1, "emit_after_discard");
        chk("discard_target", 128'(emit_pcs[mark]), 128'(32'h0000_0200));

        // PC wrap at the top of the address space
        lat = 1;
        step(0, 1, 32'hFFFF_FFF8, 1);
        #1;
        mark = emitted;
        wait_emits(mark + 3, "emit_wrap");
        chk("wrap_pc0", 128'(emit_pcs[mark]), 128'(32'hFFFF_FFF8));
        chk("wrap_pc1", 128'(emit_pcs[mark + 1]), 128'(32'hFFFF_FFFC));
        chk("wrap_pc2", 128'(emit_pcs[mark + 2]), 128'(32'h0000_0000));

        // Reset with a full buffer
        for (int i = 0; i < 8; i++) step(1, 0, 32'h0, 1);
        step(0, 0, 32'h0, 0);
        #1;
        mark = emitted;
        wait_emits(mark + 1, "emit_after_reset");
        chk("reset_restart_pc", 128'(emit_pcs[mark]), 128'(T_RESET_PC));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 99) != 0);
        end

        // Drain: memory accepts no new requests, buffer must empty completely
        pause = 1;
        run(20);
        #1;
        chk("drain_empty", 128'(q.size()), 128'(0));
        chk("total_emitted", 128'(emitted > 200), 128'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
